// File: rtl/comm_responder.sv
// DUT-side UART command link: two-byte host commands in, single-byte responses out.
// Optional inter-byte timeout on the low byte is enabled with `define CMD_TIMEOUT_EN.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized RX line
// START    | half-bit wait, confirm start bit is still low
// DATA     | 8 data samples, LSB first
// STOP     | stop sample; high completes the byte, low is a framing error
// WAIT_HI  | byte FSM expects the high command byte
// WAIT_LO  | byte FSM holds hi_buf and expects the low byte
// TX_IDLE  | transmitter idle, line high, send_resp accepted
// TSTART   | driving start bit
// TDATA    | driving 8 data bits, LSB first
// TSTOP    | driving stop bit; resp_sent pulses when it ends

module comm_responder #(
   parameter int unsigned BAUD_DIV    = 108,
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        send_resp,
   output logic        resp_sent,
   output logic        tx_busy,
   output logic        frm_err
);

   localparam int unsigned CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BIT_LD  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);

   if (BAUD_DIV < 4 || TIMEOUT_CYC == 0) begin : g_param_chk
      $error("comm_responder: BAUD_DIV must be >= 4 and TIMEOUT_CYC nonzero");
   end

   typedef enum logic [1:0] {RX_IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic       {WAIT_HI, WAIT_LO}           byte_state_t;
   typedef enum logic [1:0] {TX_IDLE, TSTART, TDATA, TSTOP} tx_state_t;

   rx_state_t   rx_st;
   byte_state_t byte_st;
   tx_state_t   tx_st;

   logic [1:0]    rx_sync;
   logic          rx_s;
   logic          rx_prev;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic [7:0]    hi_buf;

   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;

   logic rx_tc, byte_done, stop_err, start_ok, tx_tc;

   assign rx_s      = rx_sync[1];
   assign rx_tc     = (rx_cnt == '0);
   assign byte_done = (rx_st == STOP)  && rx_tc &&  rx_s;
   assign stop_err  = (rx_st == STOP)  && rx_tc && !rx_s;
   assign start_ok  = (rx_st == START) && rx_tc && !rx_s;
   assign tx_tc     = (tx_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync  <= 2'b11;
         rx_prev  <= 1'b1;
         rx_st    <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_sync <= {rx_sync[0], RX};
         rx_prev <= rx_s;
         case (rx_st)
            RX_IDLE: begin
               if (rx_prev && !rx_s) begin
                  rx_st  <= START;
                  rx_cnt <= HALF_LD;
               end
            end
            START: begin
               if (rx_tc) begin
                  if (rx_s) begin
                     rx_st <= RX_IDLE;
                  end else begin
                     rx_st  <= DATA;
                     rx_cnt <= BIT_LD;
                     rx_bit <= '0;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            DATA: begin
               if (rx_tc) begin
                  rx_shift <= {rx_s, rx_shift[7:1]};
                  rx_cnt   <= BIT_LD;
                  rx_bit   <= rx_bit + 1'b1;
                  if (rx_bit == 3'd7) rx_st <= STOP;
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            STOP: begin
               if (rx_tc) rx_st <= RX_IDLE;
               else       rx_cnt <= rx_cnt - 1'b1;
            end
         endcase
      end
   end

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_LD = TW'(TIMEOUT_CYC - 1);
   logic [TW-1:0] to_cnt;
`endif

   // Later assignments override earlier ones, so a set beats a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_st <= WAIT_HI;
         hi_buf  <= '0;
         cmd     <= '0;
         cmd_rdy <= 1'b0;
         frm_err <= 1'b0;
`ifdef CMD_TIMEOUT_EN
         to_cnt  <= '0;
`endif
      end else begin
         if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            frm_err <= 1'b0;
         end
         if (start_ok && byte_st == WAIT_HI) cmd_rdy <= 1'b0;
         if (stop_err) frm_err <= 1'b1;
         case (byte_st)
            WAIT_HI: begin
               if (byte_done) begin
                  hi_buf  <= rx_shift;
                  byte_st <= WAIT_LO;
`ifdef CMD_TIMEOUT_EN
                  to_cnt  <= TO_LD;
`endif
               end
            end
            WAIT_LO: begin
               if (byte_done) begin
                  cmd     <= {hi_buf, rx_shift};
                  cmd_rdy <= 1'b1;
                  byte_st <= WAIT_HI;
               end
`ifdef CMD_TIMEOUT_EN
               else if (to_cnt == '0) begin
                  byte_st <= WAIT_HI;
                  hi_buf  <= '0;
                  frm_err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt - 1'b1;
               end
`endif
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st     <= TX_IDLE;
         TX        <= 1'b1;
         tx_busy   <= 1'b0;
         resp_sent <= 1'b0;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
      end else begin
         resp_sent <= 1'b0;
         case (tx_st)
            TX_IDLE: begin
               if (send_resp) begin
                  tx_shift <= resp;
                  TX       <= 1'b0;
                  tx_busy  <= 1'b1;
                  tx_cnt   <= BIT_LD;
                  tx_st    <= TSTART;
               end
            end
            TSTART: begin
               if (tx_tc) begin
                  TX       <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_cnt   <= BIT_LD;
                  tx_bit   <= '0;
                  tx_st    <= TDATA;
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end
            TDATA: begin
               if (tx_tc) begin
                  tx_cnt <= BIT_LD;
                  if (tx_bit == 3'd7) begin
                     TX    <= 1'b1;
                     tx_st <= TSTOP;
                  end else begin
                     TX       <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 1'b1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end
            TSTOP: begin
               if (tx_tc) begin
                  tx_busy   <= 1'b0;
                  resp_sent <= 1'b1;
                  tx_st     <= TX_IDLE;
               end else begin
                  tx_cnt <= tx_cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comm_responder.sv
// Scoreboard bench for comm_responder: host byte stream and responses are modelled
// at byte/command level; independent monitors decode cmd_rdy events and the TX line.

module tb_comm_responder;

   localparam int B  = 8;
   localparam int TO = 200;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RX = 1'b1;
   logic        TX;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy = 1'b0;
   logic [7:0]  resp = 8'h00;
   logic        send_resp = 1'b0;
   logic        resp_sent;
   logic        tx_busy;
   logic        frm_err;

   comm_responder #(.BAUD_DIV(B), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
      .resp_sent(resp_sent), .tx_busy(tx_busy), .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] cmd_q[$];
   logic [7:0]  tx_q[$];
   bit          have_hi = 1'b0;
   logic [7:0]  hi_m = 8'h00;
   int          lo_start = 0;
   bit          tx_skip = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Host-side 8N1 byte; the model decides what the byte means before the stop bit.
   task automatic host_byte(input logic [7:0] b, input bit bad, input bit clr_stop);
      bit completes;
      completes = have_hi && !bad;
      @(negedge clk);
      RX = 1'b0;
      if (completes) lo_start = cyc;
      tick(B);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         tick(B);
      end
      if (!bad) begin
         if (!have_hi) begin
            hi_m    = b;
            have_hi = 1'b1;
         end else begin
            cmd_q.push_back({hi_m, b});
            have_hi = 1'b0;
         end
      end
      RX = ~bad;
      if (clr_stop) clr_cmd_rdy = 1'b1;
      for (int k = 0; k < 3*B; k++) begin
         if (k == B) RX = 1'b1;
         @(negedge clk);
         if (clr_cmd_rdy && cmd_rdy) clr_cmd_rdy = 1'b0;
      end
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic glitch();
      @(negedge clk);
      RX = 1'b0;
      tick(2);
      RX = 1'b1;
      tick(3*B);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int k;
      k = 0;
      while (tx_busy && k < maxc) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(tx_busy), 32'd0);
   endtask

   // cmd monitor: every rising cmd_rdy must match the oldest expected command.
   initial begin
      logic        prev_rdy;
      logic [15:0] prev_cmd;
      logic [15:0] e;
      logic        in_win;
      prev_rdy = 1'b0;
      prev_cmd = 16'h0000;
      wait (rst_n === 1'b1);
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (cmd_rdy && !prev_rdy) begin
               if (cmd_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_cmd: got %h with no command expected", cmd);
               end else begin
                  e = cmd_q.pop_front();
                  check("cmd_value", 32'(cmd), 32'(e));
                  in_win = (cyc - lo_start >= 9*B) && (cyc - lo_start <= 10*B + 4);
                  check("cmd_rdy_latency", 32'(in_win), 32'd1);
               end
            end else begin
               check("cmd_stable", 32'(cmd), 32'(prev_cmd));
            end
         end
         prev_rdy = cmd_rdy;
         prev_cmd = cmd;
      end
   end

   // TX monitor: decode each frame at bit centres.
   initial begin
      logic [7:0] d;
      logic       s0, s9;
      d = 8'h00;
      wait (rst_n === 1'b1);
      forever begin
         @(negedge clk);
         if (rst_n && TX === 1'b0) begin
            repeat (B/2 - 1) @(negedge clk);
            s0 = TX;
            for (int i = 0; i < 8; i++) begin
               repeat (B) @(negedge clk);
               d[i] = TX;
            end
            repeat (B) @(negedge clk);
            s9 = TX;
            if (!tx_skip) begin
               if (tx_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL tx_unexpected_frame: got byte %h with none expected", d);
               end else begin
                  check("tx_start_bit", 32'(s0), 32'd0);
                  check("tx_byte", 32'(d), 32'(tx_q.pop_front()));
                  check("tx_stop_bit", 32'(s9), 32'd1);
               end
            end
         end
      end
   end

   initial begin
      logic [9:0]  frame;
      int          pulses, pulse_at, k;
      logic [15:0] c;

      tick(3);
      check("rst_TX", 32'(TX), 32'd1);
      check("rst_cmd", 32'(cmd), 32'h0000);
      check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
      check("rst_resp_sent", 32'(resp_sent), 32'd0);
      check("rst_tx_busy", 32'(tx_busy), 32'd0);
      check("rst_frm_err", 32'(frm_err), 32'd0);
      rst_n = 1'b1;
      tick(5);

      // basic command, hold until cleared
      host_byte(8'h01, 1'b0, 1'b0);
      host_byte(8'h35, 1'b0, 1'b0);
      tick(20);
      check("cmd_rdy_hold", 32'(cmd_rdy), 32'd1);
      pulse_clr();
      check("cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);
      check("cmd_after_clr", 32'(cmd), 32'h0135);

      // response frame A5, cycle-exact, with ignored and back-to-back sends
      frame = {1'b1, 8'hA5, 1'b0};
      tx_q.push_back(8'hA5);
      @(negedge clk);
      resp = 8'hA5;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      resp = 8'h00;
      pulses = 0;
      pulse_at = -1;
      for (int j = 0; j <= 84; j++) begin
         if (j > 0) @(negedge clk);
         if (j % 8 == 3 && j < 80) check($sformatf("a5_bit%0d", j/8), 32'(TX), 32'(frame[j/8]));
         if (resp_sent) begin
            pulses++;
            pulse_at = j;
         end
         if (j == 0) check("tx_busy_set", 32'(tx_busy), 32'd1);
         if (j == 19) begin
            resp = 8'hFF;
            send_resp = 1'b1;
         end
         if (j == 20) send_resp = 1'b0;
         if (j == 80) begin
            check("tx_busy_end", 32'(tx_busy), 32'd0);
            resp = 8'h3C;
            send_resp = 1'b1;
            tx_q.push_back(8'h3C);
         end
         if (j == 81) begin
            send_resp = 1'b0;
            check("back_to_back_start", 32'(TX), 32'd0);
         end
      end
      check("resp_sent_count", 32'(pulses), 32'd1);
      check("resp_sent_cycle", 32'(pulse_at), 32'd80);
      wait_idle("tx_idle_after_b2b", 200);

      // RX glitch in idle
      glitch();
      check("glitch_cmd_rdy", 32'(cmd_rdy), 32'd0);
      check("glitch_frm_err", 32'(frm_err), 32'd0);

      // framing error byte not counted; low byte's set beats a held clear
      host_byte(8'h46, 1'b1, 1'b0);
      check("frm_err_set", 32'(frm_err), 32'd1);
      host_byte(8'h02, 1'b0, 1'b0);
      check("frm_err_sticky", 32'(frm_err), 32'd1);
      host_byte(8'h10, 1'b0, 1'b1);
      check("set_wins_over_clr", 32'(cmd_rdy), 32'd1);
      check("frm_err_cleared", 32'(frm_err), 32'd0);
      check("cmd_0210", 32'(cmd), 32'h0210);
      pulse_clr();

      // new command while previous still pending
      host_byte(8'h01, 1'b0, 1'b0);
      host_byte(8'h35, 1'b0, 1'b0);
      check("pending_rdy", 32'(cmd_rdy), 32'd1);
      fork
         begin
            host_byte(8'h46, 1'b0, 1'b0);
            host_byte(8'h01, 1'b0, 1'b0);
         end
         begin
            tick(5*B);
            check("rdy_drop_at_start", 32'(cmd_rdy), 32'd0);
            check("cmd_hold_hi", 32'(cmd), 32'h0135);
            tick(10*B);
            check("cmd_hold_lo", 32'(cmd), 32'h0135);
         end
      join
      check("new_cmd_rdy", 32'(cmd_rdy), 32'd1);
      check("new_cmd", 32'(cmd), 32'h4601);
      pulse_clr();

`ifdef CMD_TIMEOUT_EN
      host_byte(8'h08, 1'b0, 1'b0);
      tick(250);
      have_hi = 1'b0;
      check("timeout_frm_err", 32'(frm_err), 32'd1);
      host_byte(8'h02, 1'b0, 1'b0);
      host_byte(8'h33, 1'b0, 1'b0);
      check("timeout_cmd", 32'(cmd), 32'h0233);
      pulse_clr();
`endif

      // randomized full-duplex traffic
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               k = $urandom_range(0, 3);
               if (k == 0) glitch();
               if (k == 1) host_byte(8'($urandom), 1'b1, 1'b0);
               c = 16'($urandom);
               host_byte(c[15:8], 1'b0, 1'b0);
               host_byte(c[7:0], 1'b0, 1'b0);
               tick($urandom_range(0, 30));
            end
         end
         begin
            for (int i = 0; i < 14; i++) begin
               tick($urandom_range(1, 60));
               wait_idle("rand_tx_idle", 200);
               resp = 8'($urandom);
               send_resp = 1'b1;
               tx_q.push_back(resp);
               @(negedge clk);
               send_resp = 1'b0;
               if ($urandom_range(0, 2) == 0) begin
                  tick(10);
                  resp = 8'($urandom);
                  send_resp = 1'b1;
                  @(negedge clk);
                  send_resp = 1'b0;
               end
            end
         end
      join

      k = 0;
      while ((cmd_q.size() != 0 || tx_q.size() != 0) && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
      check("tx_q_drained", 32'(tx_q.size()), 32'd0);
      wait_idle("tx_idle_before_reset", 200);

      // reset in the middle of a response frame
      tx_skip = 1'b1;
      @(negedge clk);
      resp = 8'h5A;
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      tick(10);
      check("pre_reset_tx_low", 32'(TX), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_TX", 32'(TX), 32'd1);
      check("midrst_tx_busy", 32'(tx_busy), 32'd0);
      check("midrst_cmd", 32'(cmd), 32'h0000);
      tick(3);
      rst_n = 1'b1;
      have_hi = 1'b0;
      tick(100);
      tx_skip = 1'b0;
      check("post_reset_TX", 32'(TX), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
